// File: rtl/forward_scoreboard.sv
// Operand-forwarding and hazard unit: per-operand bypass selects, one decode stall,
// and a registered scoreboard for long-latency ops that write back out of band.
module forward_scoreboard #(
   parameter int NSRC   = 2,
   parameter int NSTAGE = 2,
   parameter int NREG   = 32,
   parameter int RW     = 5,
   parameter int SELW   = 2,
   parameter int CNTW   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_de_valid,
   input  logic [NSRC*RW-1:0]   i_de_rs,
   input  logic [RW-1:0]        i_de_rd,
   input  logic                 i_de_long,
   input  logic                 i_de_issue,
   input  logic                 i_flush,
   input  logic [NSTAGE-1:0]    i_stage_valid,
   input  logic [NSTAGE*RW-1:0] i_stage_rd,
   input  logic [NSTAGE-1:0]    i_stage_ready,
   input  logic                 i_wb_valid,
   input  logic [RW-1:0]        i_wb_rd,
   output logic [NSRC*SELW-1:0] o_fwd_sel,
   output logic                 o_stall,
   output logic [NREG-1:0]      o_sb_busy,
   output logic [CNTW-1:0]      o_stall_count
);
   localparam logic [SELW-1:0] SEL_RF = '0;
   localparam logic [SELW-1:0] SEL_WB = SELW'(NSTAGE + 1);

   logic [NREG-1:0]   r_busy;
   logic [NREG-1:0]   w_busy_next;
   logic [CNTW-1:0]   r_stall_count;
   logic [NSTAGE-1:0] w_stage_live;
   logic [NSRC-1:0]   w_src_haz;
   logic              w_waw_haz;
   logic              w_stall;
   logic              w_set;
   logic              w_clear;

   // A stage writing x0 never provides a value worth bypassing.
   for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
      assign w_stage_live[gi] = i_stage_valid[gi] & (i_stage_rd[gi*RW +: RW] != '0);
   end

   for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic [RW-1:0]   w_rs;
      logic [SELW-1:0] w_sel;
      logic            w_haz;

      assign w_rs = i_de_rs[gi*RW +: RW];

      // Lowest priority first; the stage scan runs oldest to youngest so the youngest writer wins.
      always_comb begin
         w_sel = SEL_RF;
         w_haz = 1'b0;
         if (w_rs != '0) begin
            w_haz = r_busy[w_rs];
            if (i_wb_valid && (i_wb_rd == w_rs)) begin
               w_sel = SEL_WB;
               w_haz = 1'b0;
            end
            for (int i = NSTAGE - 1; i >= 0; i--) begin
               if (w_stage_live[i] && (i_stage_rd[i*RW +: RW] == w_rs)) begin
                  w_sel = SELW'(i + 1);
                  w_haz = ~i_stage_ready[i];
               end
            end
         end
      end

      assign o_fwd_sel[gi*SELW +: SELW] = w_sel;
      assign w_src_haz[gi]              = w_haz;
   end

   // A second long op to a still-pending register must wait unless the old one retires now.
   assign w_waw_haz = i_de_long && (i_de_rd != '0) && r_busy[i_de_rd]
                      && !(i_wb_valid && (i_wb_rd == i_de_rd));

   assign w_stall = i_de_valid & ((|w_src_haz) | w_waw_haz);

   assign w_set   = i_de_valid & i_de_issue & i_de_long & ~w_stall & ~i_flush & (i_de_rd != '0);
   assign w_clear = i_wb_valid & (i_wb_rd != '0);

   // Set overrides clear so a re-issued op keeps ownership of its destination.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
         assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
         assign w_busy_next[gi] = (r_busy[gi] & ~(w_clear & (i_wb_rd == RW'(gi))))
                                | (w_set & (i_de_rd == RW'(gi)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy        <= '0;
         r_stall_count <= '0;
      end else begin
         r_busy <= w_busy_next;
         if (w_stall && (r_stall_count != {CNTW{1'b1}})) begin
            r_stall_count <= r_stall_count + CNTW'(1);
         end
      end
   end

   assign o_stall       = w_stall;
   assign o_sb_busy     = r_busy;
   assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench: driver pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_forward_scoreboard;
   localparam int NSRC = 2, NSTAGE = 2, NREG = 32, RW = 5, SELW = 2, CNTW = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 de_valid, de_long, de_issue, flush, wb_valid;
   logic [NSRC*RW-1:0]   de_rs;
   logic [RW-1:0]        de_rd, wb_rd;
   logic [NSTAGE-1:0]    stage_valid, stage_ready;
   logic [NSTAGE*RW-1:0] stage_rd;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 stall;
   logic [NREG-1:0]      sb_busy;
   logic [CNTW-1:0]      stall_count;

   typedef struct {
      string           name;
      logic [3:0]      sel;
      logic            stall;
      logic [31:0]     busy;
      logic [3:0]      cnt;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   forward_scoreboard #(
      .NSRC(NSRC), .NSTAGE(NSTAGE), .NREG(NREG), .RW(RW), .SELW(SELW), .CNTW(CNTW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_de_valid    (de_valid),
      .i_de_rs       (de_rs),
      .i_de_rd       (de_rd),
      .i_de_long     (de_long),
      .i_de_issue    (de_issue),
      .i_flush       (flush),
      .i_stage_valid (stage_valid),
      .i_stage_rd    (stage_rd),
      .i_stage_ready (stage_ready),
      .i_wb_valid    (wb_valid),
      .i_wb_rd       (wb_rd),
      .o_fwd_sel     (fwd_sel),
      .o_stall       (stall),
      .o_sb_busy     (sb_busy),
      .o_stall_count (stall_count)
   );

   task automatic idle();
      de_valid = 0; de_rs = '0; de_rd = '0; de_long = 0; de_issue = 0; flush = 0;
      stage_valid = '0; stage_rd = '0; stage_ready = '0; wb_valid = 0; wb_rd = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic vec(input string name, input logic [1:0] s0, input logic [1:0] s1,
                      input logic st, input logic [31:0] b, input logic [3:0] c);
      exp_t e;
      e.name  = name;
      e.sel   = {s1, s0};
      e.stall = st;
      e.busy  = b;
      e.cnt   = c;
      q.push_back(e);
   endtask

   // Monitor: outputs are stable mid-cycle, between input changes and the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            $display("[%0t] %s sel=%h stall=%0b busy=%h cnt=%0d", $time, e.name,
                     fwd_sel, stall, sb_busy, stall_count);
            if (fwd_sel !== e.sel) begin
               n_miss++;
               $display("FAIL %s fwd_sel got %h want %h", e.name, fwd_sel, e.sel);
            end
            if (stall !== e.stall) begin
               n_miss++;
               $display("FAIL %s stall got %0b want %0b", e.name, stall, e.stall);
            end
            if (sb_busy !== e.busy) begin
               n_miss++;
               $display("FAIL %s sb_busy got %h want %h", e.name, sb_busy, e.busy);
            end
            if (stall_count !== e.cnt) begin
               n_miss++;
               $display("FAIL %s stall_count got %0d want %0d", e.name, stall_count, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      // Reset held low at start
      next_cycle();
      vec("reset", 2'd0, 2'd0, 0, 32'h0, 4'd0);
      #2 rst_n = 1'b1;

      // Forwarding: youngest writer wins
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd5}; stage_valid = 2'b11;
      stage_rd = {5'd5, 5'd5}; stage_ready = 2'b11;
      vec("fwd_both", 2'd1, 2'd0, 0, 32'h0, 4'd0);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd5}; stage_valid = 2'b10;
      stage_rd = {5'd5, 5'd5}; stage_ready = 2'b11;
      vec("fwd_old", 2'd2, 2'd0, 0, 32'h0, 4'd0);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd5}; stage_valid = 2'b01;
      stage_rd = {5'd5, 5'd5}; stage_ready = 2'b10;
      vec("fwd_young_notrdy", 2'd1, 2'd0, 1, 32'h0, 4'd0);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd5}; stage_valid = 2'b11;
      stage_rd = {5'd5, 5'd5}; stage_ready = 2'b10;
      vec("fwd_young_wins", 2'd1, 2'd0, 1, 32'h0, 4'd1);

      // Load-use on operand 1
      for (int i = 0; i < 2; i++) begin
         next_cycle(); de_valid = 1; de_rs = {5'd7, 5'd0}; stage_valid = 2'b01;
         stage_rd = {5'd0, 5'd7}; stage_ready = 2'b00;
         vec("load_use", 2'd0, 2'd1, 1, 32'h0, 4'(2 + i));
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle(); de_valid = 1; de_rs = {5'd7, 5'd0}; stage_valid = 2'b01;
         stage_rd = {5'd0, 5'd7}; stage_ready = 2'b01;
         vec("load_ready", 2'd0, 2'd1, 0, 32'h0, 4'd4);
      end
      next_cycle(); de_valid = 0; de_rs = {5'd7, 5'd0}; stage_valid = 2'b01;
      stage_rd = {5'd0, 5'd7}; stage_ready = 2'b00;
      vec("invalid_no_stall", 2'd0, 2'd1, 0, 32'h0, 4'd4);

      // Scoreboard
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd9;
      vec("long_issue9", 2'd0, 2'd0, 0, 32'h0, 4'd4);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd9};
      vec("sb_hazard9", 2'd0, 2'd0, 1, 32'h200, 4'd4);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd9}; wb_valid = 1; wb_rd = 5'd9;
      vec("wb_bypass9", 2'd3, 2'd0, 0, 32'h200, 4'd5);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd9};
      vec("sb_cleared9", 2'd0, 2'd0, 0, 32'h0, 4'd5);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd9;
      vec("long_reissue9", 2'd0, 2'd0, 0, 32'h0, 4'd5);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd9;
      wb_valid = 1; wb_rd = 5'd9;
      vec("set_clear_same", 2'd0, 2'd0, 0, 32'h200, 4'd5);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd9;
      vec("waw_stall", 2'd0, 2'd0, 1, 32'h200, 4'd5);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd10;
      de_rs = {5'd0, 5'd9};
      vec("stalled_no_set", 2'd0, 2'd0, 1, 32'h200, 4'd6);
      next_cycle();
      vec("after_stall", 2'd0, 2'd0, 0, 32'h200, 4'd7);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd0;
      vec("long_rd0", 2'd0, 2'd0, 0, 32'h200, 4'd7);
      next_cycle(); de_valid = 1; de_issue = 1; de_long = 1; de_rd = 5'd11; flush = 1;
      vec("flush_long", 2'd0, 2'd0, 0, 32'h200, 4'd7);
      next_cycle();
      vec("no_set_rd0_flush", 2'd0, 2'd0, 0, 32'h200, 4'd7);
      next_cycle(); de_valid = 1; de_rs = {5'd12, 5'd0}; wb_valid = 1; wb_rd = 5'd12;
      vec("wb_nonbusy", 2'd0, 2'd3, 0, 32'h200, 4'd7);
      next_cycle();
      vec("wb_noop", 2'd0, 2'd0, 0, 32'h200, 4'd7);
      next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd9}; stage_valid = 2'b01;
      stage_rd = {5'd0, 5'd9}; stage_ready = 2'b01;
      vec("stage_over_sb", 2'd1, 2'd0, 0, 32'h200, 4'd7);

      // Asynchronous reset mid-run, checked before the next rising edge
      next_cycle(); rst_n = 1'b0;
      vec("async_reset", 2'd0, 2'd0, 0, 32'h0, 4'd0);
      next_cycle(); rst_n = 1'b1; de_valid = 1; de_rs = {5'd0, 5'd9};
      wb_valid = 1; wb_rd = 5'd9;
      vec("lost_wb", 2'd3, 2'd0, 0, 32'h0, 4'd0);
      next_cycle();
      vec("lost_wb_noop", 2'd0, 2'd0, 0, 32'h0, 4'd0);

      // Counter saturation
      for (int k = 0; k < 18; k++) begin
         next_cycle(); de_valid = 1; de_rs = {5'd0, 5'd5}; stage_valid = 2'b01;
         stage_rd = {5'd0, 5'd5}; stage_ready = 2'b00;
         vec("saturate", 2'd1, 2'd0, 1, 32'h0, (k > 15) ? 4'd15 : 4'(k));
      end
      next_cycle();
      vec("sat_hold", 2'd0, 2'd0, 0, 32'h0, 4'd15);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL drain pending got %0d want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
Parametrised operand-forwarding and hazard unit for the in-order pipeline.
- Generalises two-stage EX/MEM forwarding to NSTAGE in-flight stages and NSRC source operands.
- Adds a registered scoreboard for long-latency ops (divide, cache-miss loads) that leave the pipeline and write back out of band.
- Sits beside decode: drives per-operand bypass selects and a single decode stall.

Parameters:
NSRC, 2, number of source operands checked per decoded instruction
NSTAGE, 2, number of forwarding stages; index 0 is youngest (EX), NSTAGE-1 oldest
NREG, 32, architectural registers; register 0 is hardwired zero
RW, 5, register index width, clog2(NREG)
SELW, 2, select width, clog2(NSTAGE+2)
CNTW, 16, stall performance counter width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
de_valid  in  1  decode holds a valid instruction
de_rs  in  NSRC*RW  source register indices, operand k at [k*RW +: RW]
de_rd  in  RW  decode destination register
de_long  in  1  decode instruction is long-latency (tracked by scoreboard)
de_issue  in  1  decode instruction advances this cycle if not stalled
flush  in  1  pipeline flush; suppresses scoreboard set this cycle
stage_valid  in  NSTAGE  stage i holds a valid register-writing instruction
stage_rd  in  NSTAGE*RW  stage i destination, at [i*RW +: RW]
stage_ready  in  NSTAGE  stage i result is available for bypass (0 e.g. load data pending)
wb_valid  in  1  long-latency unit writes back this cycle
wb_rd  in  RW  long-latency writeback destination
fwd_sel  out  NSRC*SELW  per operand: 0 regfile, i+1 stage i, NSTAGE+1 long-latency writeback
stall  out  1  decode must hold
sb_busy  out  NREG  registered scoreboard pending bits; bit 0 always 0
stall_count  out  CNTW  saturating count of stalled cycles

Behaviour:
Per-operand resolution (combinational, for each operand k with index rs):
- rs == 0: sel 0, no hazard.
- Else scan stages 0..NSTAGE-1; the first with stage_valid[i] & stage_rd[i] != 0 & stage_rd[i] == rs wins.
  - sel = i+1.
  - hazard = !stage_ready[i].
  - Older stages and the scoreboard are ignored: the youngest writer wins.
- Else if wb_valid & wb_rd == rs: sel = NSTAGE+1, no hazard (same-cycle writeback bypass).
- Else if sb_busy[rs]: sel 0, hazard.
- Else sel 0, no hazard.

Stall:
- WAW hazard = de_long & de_rd != 0 & sb_busy[de_rd] & !(wb_valid & wb_rd == de_rd).
- stall = de_valid & (OR of operand hazards | WAW hazard).
- fwd_sel is driven regardless of de_valid; decode ignores it when invalid.

Scoreboard (registered, clk rising edge):
- set = de_valid & de_issue & de_long & !stall & !flush & de_rd != 0.
- clear = wb_valid & wb_rd != 0.
- Next busy[r] = (busy[r] & !(clear & wb_rd == r)) | (set & de_rd == r).
- Set and clear of the same register in the same cycle leaves it busy (the new op owns it).
- busy[0] is never set.
- wb_valid for a non-busy register is legal and a no-op.
- flush does not clear pending bits: long ops are committed once issued.

stall_count:
- Increments by 1 each cycle stall = 1.
- Saturates at all-ones and does not wrap.

Reset (rst_n low, asynchronous):
- sb_busy = 0 and stall_count = 0 immediately.
- Combinational outputs then follow inputs against an empty scoreboard.
- Reset mid-operation discards all pending bits; a later wb_valid for a lost register is a no-op.

Latency:
- fwd_sel and stall have zero-cycle combinational latency from inputs and sb_busy.
- A scoreboard set is visible to the following decode cycle.

Test Plan:
- Operand 0 = x5; stage0 and stage1 both valid with rd=5, stage_ready=11 -> fwd_sel[0]=1, stall=0; drop stage0 valid -> fwd_sel[0]=2.
- Stage0 rd=7, stage_ready[0]=0 (load pending), operand 1 = x7 -> stall=1, stall_count increments per cycle; raise stage_ready[0] -> stall=0, fwd_sel[1]=1.
- Issue long op rd=9 -> sb_busy[9]=1 next cycle; operand 0 = x9 -> stall=1; wb_valid with wb_rd=9 -> stall=0 same cycle, fwd_sel[0]=3 (NSTAGE=2), sb_busy[9]=0 after the edge.
- Same cycle: wb clears x9 while a new long op issues rd=9 -> sb_busy[9] stays 1. Long op rd=9 while busy with no wb -> stall=1 (WAW), no set.
- Operand index 0, or de_rd=0 long issue -> fwd_sel=0, no stall, sb_busy unchanged. flush with long issue -> no set.
- Pre-set stall_count near saturation by stalling 2^CNTW cycles (use CNTW=4 build) -> holds at 15. Assert rst_n=0 asynchronously mid-run -> sb_busy=0 and stall_count=0 before the next clock edge.
